// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state encoding
// and the alignment helper used when LSU_MISALIGN_TRAP_EN is defined.
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_STORE = 3'd2,
    ST_RMW   = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extracts and extends the addressed byte/halfword of a
// loaded word, and merges store data into the addressed lanes of the old word.
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords ignore addr[0]; the trap build rejects those requests before they get here.
  assign byte_off = {lane_i, 3'b000};
  assign half_off = {lane_i[1], 4'b0000};

  always_comb begin
    byte_sel     = rdata_i[byte_off +: 8];
    half_sel     = rdata_i[half_off +: 16];
    load_data_o  = 32'h0000_0000;
    merge_data_o = rdata_i;
    case (size_i)
      SIZE_B: begin
        load_data_o                = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merge_data_o[byte_off +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        load_data_o                 = {{16{signed_i & half_sel[15]}}, half_sel};
        merge_data_o[half_off +: 16] = wdata_i[15:0];
      end
      SIZE_W: begin
        load_data_o  = rdata_i;
        merge_data_o = wdata_i;
      end
      default: begin
        load_data_o  = 32'h0000_0000;
        merge_data_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide DataMemory: one request at a time,
// sub-word stores via read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              req_err;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  always_comb begin
    req_err = (req_size == SIZE_RSV);
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = req_err | is_misaligned(req_size, req_addr[1:0]);
`endif
  end

  load_store_unit_lane_align u_lane_align (
    .size_i       (size_q),
    .signed_i     (signed_q),
    .lane_i       (addr_q[1:0]),
    .rdata_i      (mem_read_data),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      size_q      <= SIZE_B;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            size_q      <= req_size;
            signed_q    <= req_signed;
            wdata_q     <= req_wdata;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (!req_we) begin
              state_q <= ST_LOAD;
            end else if (req_size == SIZE_W) begin
              state_q     <= ST_STORE;
              mem_wdata_q <= req_wdata;
            end else begin
              state_q <= ST_RMW;
            end
          end
        end
        ST_LOAD: begin
          rsp_rdata_q <= load_data;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        // The old word is on mem_read_data this cycle; the merged word is written next.
        ST_RMW: begin
          mem_wdata_q <= merge_data;
          state_q     <= ST_STORE;
        end
        ST_STORE: begin
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign mem_address      = {2'b00, addr_q[ADDR_W-1:2]};
  assign mem_write_data   = mem_wdata_q;
  // Gating with rst keeps a reset during STORE from landing a write on that edge.
  assign mem_write_enable = (state_q == ST_STORE) && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases with literal expectations,
// then randomized traffic checked cycle by cycle against a byte-lane reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  // DataMemory stand-in: 16 words, combinational read, write on rising edge.
  logic [31:0] mem [16];
  logic        mem_load;
  logic [3:0]  load_idx;
  logic [31:0] load_val;
  int          mem_wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_load) mem[load_idx] <= load_val;
    else if (mem_write_enable) begin
      mem[mem_address[3:0]] <= mem_write_data;
      mem_wr_cnt <= mem_wr_cnt + 1;
    end
  end
  assign mem_read_data = mem[mem_address[3:0]];

  // Reference state
  logic [31:0] ref_mem [16];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          pending = 0;
  bit          in_rst = 1;
  int          exp_cycle;
  logic [31:0] exp_rdata, exp_addr, exp_new;
  bit          exp_err, exp_store;
  int          exp_wr, exp_idx;
  int          wr_base = 0;
  logic [31:0] got_rdata;
  logic        got_err;

  function automatic bit ref_err(input int size, input int addr);
    if (size == 3) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 1 && (addr % 2) != 0) return 1'b1;
    if (size == 2 && (addr % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int lane_shift(input int size, input int addr);
    if (size == 0) return (addr % 4) * 8;
    if (size == 1) return ((addr / 2) % 2) * 16;
    return 0;
  endfunction

  function automatic logic [31:0] size_mask(input int size);
    if (size == 0) return 32'h0000_00FF;
    if (size == 1) return 32'h0000_FFFF;
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int size, input bit sgn, input int addr);
    logic [31:0] v;
    v = (w >> lane_shift(size, addr)) & size_mask(size);
    if (sgn && size == 0 && v[7])  v = v | 32'hFFFF_FF00;
    if (sgn && size == 1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input int size, input int addr, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    sh = lane_shift(size, addr);
    m = size_mask(size);
    return (old & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison of all DUT outputs against the model's expectations.
  task automatic check_cycle();
    bit ev;
    ev = pending && (cyc == exp_cycle);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
    if (!in_rst) chk("req_ready", {31'd0, req_ready}, {31'd0, !pending});
    if (!pending) chk("idle_no_write", {31'd0, mem_write_enable}, 32'd0);
    if (pending && !exp_err) chk("mem_address", mem_address, exp_addr);
    if (mem_write_enable) chk("mem_write_data", mem_write_data, exp_new);
    if (ev) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
      if (exp_store) ref_mem[exp_idx] = exp_new;
      chk("write_count", 32'(mem_wr_cnt - wr_base), 32'(exp_wr));
      wr_base = mem_wr_cnt;
      if (exp_store) chk("mem_word", mem[exp_idx], ref_mem[exp_idx]);
      pending = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic issue(input bit we, input int size, input bit sgn, input int addr, input logic [31:0] wd);
    int t;
    int lat;
    bit e;
    t = 0;
    while (!req_ready && t < 20) begin
      tick();
      t++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: req_ready=0 required=1");
    end
    e = ref_err(size, addr);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = 2'(size);
    req_signed = sgn;
    req_addr   = 32'(addr);
    req_wdata  = wd;
    exp_err    = e;
    exp_idx    = (addr / 4) % 16;
    exp_addr   = 32'(addr / 4);
    exp_store  = we && !e;
    exp_wr     = exp_store ? 1 : 0;
    exp_new    = exp_store ? ref_store(ref_mem[exp_idx], size, addr, wd) : ref_mem[exp_idx];
    exp_rdata  = (!we && !e) ? ref_load(ref_mem[exp_idx], size, sgn, addr) : 32'h0;
    if (e) lat = 1;
    else if (!we || size == 2) lat = 2;
    else lat = 3;
    exp_cycle = cyc + lat;
    pending = 1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (pending && t < 8) begin
      tick();
      t++;
    end
    if (pending) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: rsp_valid=0 required=1");
      pending = 0;
    end
  endtask

  task automatic xfer(input bit we, input int size, input bit sgn, input int addr, input logic [31:0] wd);
    issue(we, size, sgn, addr, wd);
    wait_rsp();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    int          base;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_load = 1'b0; load_idx = 4'h0; load_val = 32'h0;

    for (int i = 0; i < 16; i++) begin
      load_idx = 4'(i);
      load_val = $urandom;
      ref_mem[i] = load_val;
      mem_load = 1'b1;
      tick();
    end
    mem_load = 1'b0;

    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_write_enable}, 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_mem_wdata", mem_write_data, 32'd0);
    rst = 1'b0;
    in_rst = 0;
    tick();

    xfer(1'b1, 2, 1'b0, 32'h00, 32'hA5A5_A5A5);
    chk("t1_mem0", mem[0], 32'hA5A5_A5A5);
    xfer(1'b0, 2, 1'b0, 32'h00, 32'h0);
    chk("t1_load", got_rdata, 32'hA5A5_A5A5);

    xfer(1'b1, 2, 1'b0, 32'h14, 32'h1122_3344);
    xfer(1'b1, 0, 1'b0, 32'h15, 32'h0000_00EE);
    chk("t2_mem5", mem[5], 32'h1122_EE44);
    xfer(1'b0, 0, 1'b1, 32'h15, 32'h0);
    chk("t2_sbyte", got_rdata, 32'hFFFF_FFEE);
    xfer(1'b0, 2, 1'b0, 32'h14, 32'h0);
    chk("t2_word", got_rdata, 32'h1122_EE44);

    xfer(1'b1, 2, 1'b0, 32'h18, 32'h0000_1234);
    xfer(1'b1, 1, 1'b0, 32'h1A, 32'h0000_BEEF);
    chk("t3_mem6", mem[6], 32'hBEEF_1234);
    xfer(1'b0, 1, 1'b1, 32'h1A, 32'h0);
    chk("t3_shalf", got_rdata, 32'hFFFF_BEEF);
    xfer(1'b0, 1, 1'b0, 32'h1A, 32'h0);
    chk("t3_uhalf", got_rdata, 32'h0000_BEEF);

    xfer(1'b1, 3, 1'b0, 32'h1C, 32'hDEAD_BEEF);
    chk("t4_err", {31'd0, got_err}, 32'd1);
    chk("t4_rdata", got_rdata, 32'd0);

    xfer(1'b1, 2, 1'b0, 32'h10, 32'hCAFE_8001);
    xfer(1'b0, 1, 1'b0, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t5_err", {31'd0, got_err}, 32'd1);
    chk("t5_rdata", got_rdata, 32'd0);
`else
    chk("t5_err", {31'd0, got_err}, 32'd0);
    chk("t5_rdata", got_rdata, 32'h0000_CAFE);
`endif

    // Reset while the word store sits in STORE: write and response must vanish.
    old  = mem[8];
    base = mem_wr_cnt;
    issue(1'b1, 2, 1'b0, 32'h20, 32'h5A5A_0000);
    rst = 1'b1;
    in_rst = 1;
    pending = 0;
    tick();
    rst = 1'b0;
    in_rst = 0;
    tick();
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_mem8", mem[8], old);
    chk("t6_writes", 32'(mem_wr_cnt), 32'(base));
    wr_base = mem_wr_cnt;

    for (int n = 0; n < 300; n++) begin
      int r;
      int sz;
      repeat ($urandom_range(0, 2)) tick();
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      xfer(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom);
    end

    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
